// File: rtl/lane_rr_scheduler_pkg.sv
// lane_rr_scheduler_pkg: shared lane constants and scheduler state encoding
package lane_rr_scheduler_pkg;
  localparam int NUM_LANES = 16;
  localparam int SEL_W = 4;
  typedef enum logic {ST_IDLE = 1'b0, ST_SERVE = 1'b1} state_t;
endpackage

// File: rtl/lane_mux16.sv
// lane_mux16: 16:1 bit-select lane datapath mux
module lane_mux16
  import lane_rr_scheduler_pkg::*;
(
  input  logic [NUM_LANES-1:0] data,
  input  logic [SEL_W-1:0]     sel,
  output logic                 y
);
  assign y = data[sel];
endmodule

// File: rtl/rr_pick16.sv
// rr_pick16: first requester at or after ptr, searching upward modulo 16
module rr_pick16
  import lane_rr_scheduler_pkg::*;
(
  input  logic [SEL_W-1:0]     ptr,
  input  logic [NUM_LANES-1:0] req,
  output logic [SEL_W-1:0]     winner,
  output logic                 any
);
  logic [NUM_LANES-1:0] rot;
  logic [SEL_W-1:0]     off;
  always_comb begin
    rot = NUM_LANES'({req, req} >> ptr);
    off = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) if (rot[i]) off = SEL_W'(i);
    winner = ptr + off;
    any = |req;
  end
endmodule

// File: rtl/lane_rr_scheduler.sv
// lane_rr_scheduler: round-robin select controller for a shared 16:1 lane mux
module lane_rr_scheduler
  import lane_rr_scheduler_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NUM_LANES-1:0] req,
  input  logic [NUM_LANES-1:0] lane_data,
  output logic [SEL_W-1:0]     sel,
  output logic [NUM_LANES-1:0] grant,
  output logic                 busy,
  output logic                 out,
  output logic                 out_valid
);
  state_t               state, state_n;
  logic [SEL_W-1:0]     ptr, ptr_n, sel_n, pick_ptr, winner, sel_inc;
  logic [NUM_LANES-1:0] grant_n;
  logic [3:0]           cnt, cnt_n;
  logic                 any, slot_end, mux_y;
  assign sel_inc  = sel + SEL_W'(1);
  assign slot_end = (state == ST_SERVE) && (cnt == 4'(HOLD_CYCLES - 1) || !req[sel] || !en);
  // In SERVE the arbiter only matters at slot end, so it can always look from sel+1
  assign pick_ptr = (state == ST_SERVE) ? sel_inc : ptr;
  rr_pick16 u_pick (.ptr(pick_ptr), .req(req), .winner(winner), .any(any));
  lane_mux16 u_mux (.data(lane_data), .sel(sel), .y(mux_y));
  always_comb begin
    state_n = state;
    sel_n   = sel;
    grant_n = grant;
    cnt_n   = cnt + 4'd1;
    ptr_n   = ptr;
    if (state == ST_IDLE) begin
      grant_n = '0;
      cnt_n   = '0;
    end else if (slot_end) begin
      ptr_n   = sel_inc;
      state_n = ST_IDLE;
      grant_n = '0;
    end
    if ((state == ST_IDLE || slot_end) && en && any) begin
      state_n = ST_SERVE;
      sel_n   = winner;
      grant_n = NUM_LANES'(1) << winner;
      cnt_n   = '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      sel       <= '0;
      grant     <= '0;
      cnt       <= '0;
      ptr       <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      sel       <= sel_n;
      grant     <= grant_n;
      cnt       <= cnt_n;
      ptr       <= ptr_n;
      out       <= busy ? mux_y : out;
      out_valid <= busy;
    end
  end
  assign busy = (state == ST_SERVE);
endmodule

// File: tb/tb_lane_rr_scheduler.sv
// tb_lane_rr_scheduler: directed vectors for the round-robin lane scheduler
module tb_lane_rr_scheduler;
  logic        clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [15:0] req = '0, lane_data = '0;
  logic [3:0]  sel, sel1;
  logic [15:0] grant, grant1;
  logic        busy, busy1, out, out1, out_valid, out_valid1;
  int          vectors = 0, miscompares = 0;

  lane_rr_scheduler #(.HOLD_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .lane_data(lane_data),
    .sel(sel), .grant(grant), .busy(busy), .out(out), .out_valid(out_valid));

  lane_rr_scheduler #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .req(req), .lane_data(lane_data),
    .sel(sel1), .grant(grant1), .busy(busy1), .out(out1), .out_valid(out_valid1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    en = 1'b1;
    req = 16'h0010;
    lane_data = 16'h0010;
    do_reset();
    chk("rst_grant", grant, 16'h0000);
    chk("rst_sel", 16'(sel), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_valid", 16'(out_valid), 16'd0);
    chk("rst_out", 16'(out), 16'd0);

    // single requester dwell with back-to-back regrant
    for (int k = 1; k <= 9; k++) begin
      step();
      chk("dwell_grant", grant, 16'h0010);
      chk("dwell_sel", 16'(sel), 16'd4);
      chk("dwell_valid", 16'(out_valid), (k >= 2) ? 16'd1 : 16'd0);
      if (k >= 2) chk("dwell_out", 16'(out), 16'd1);
    end

    // fairness between lanes 0 and 15
    req = 16'h8001;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      step();
      chk("rr_grant", grant, ((k >> 2) & 1) != 0 ? 16'h8000 : 16'h0001);
    end

    // wrap-around from lane 14
    req = 16'h4000;
    do_reset();
    step();
    chk("wrap_first", grant, 16'h4000);
    req = 16'hC001;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 4) chk("wrap_15", grant, 16'h8000);
      if (k == 8) chk("wrap_0", grant, 16'h0001);
      if (k == 12) chk("wrap_14", grant, 16'h4000);
    end

    // early release on the first serve cycle moves ptr to 4
    req = 16'h0008;
    do_reset();
    step();
    chk("early_grant", grant, 16'h0008);
    req = 16'h0000;
    step();
    chk("early_idle", grant, 16'h0000);
    chk("early_busy", 16'(busy), 16'd0);
    req = 16'h0018;
    step();
    chk("early_ptr", 16'(sel), 16'd4);

    // enable abort mid-slot
    req = 16'h0001;
    do_reset();
    step();
    step();
    chk("abort_valid0", 16'(out_valid), 16'd1);
    en = 1'b0;
    step();
    chk("abort_grant", grant, 16'h0000);
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_valid1", 16'(out_valid), 16'd1);
    step();
    chk("abort_valid2", 16'(out_valid), 16'd0);
    en = 1'b1;

    // asynchronous reset in the second serve cycle
    req = 16'h0004;
    do_reset();
    step();
    step();
    chk("mid_busy_pre", 16'(busy), 16'd1);
    rst = 1'b1;
    #1;
    chk("mid_grant", grant, 16'h0000);
    chk("mid_sel", 16'(sel), 16'd0);
    chk("mid_busy", 16'(busy), 16'd0);
    chk("mid_valid", 16'(out_valid), 16'd0);
    step();
    rst = 1'b0;
    step();
    chk("mid_regrant", grant, 16'h0004);
    chk("mid_resel", 16'(sel), 16'd2);

    // data lanes, every lane requesting, one-cycle hold
    req = 16'hFFFF;
    do_reset();
    for (int k = 0; k < 32; k++) begin
      lane_data = (k < 16) ? 16'h5555 : 16'hAAAA;
      step();
      chk("data_sel", 16'(sel1), 16'(k % 16));
      chk("data_grant", grant1, 16'h0001 << (k % 16));
      if (k > 0) begin
        chk("data_valid", 16'(out_valid1), 16'd1);
        chk("data_out", 16'(out1), 16'(lane_data[(k - 1) % 16]));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
